// File: rtl/i2c_pkg.sv
// Shared definitions for the heart-rate I2C target: FSM states, register
// indices and the read-side register map decode.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_ADDR,
    ST_RX_REG,
    ST_ACK_REG,
    ST_TX,
    ST_ACK_CHK,
    ST_IGNORE
  } i2c_state_e;

  localparam logic [7:0] REG_HR       = 8'h00;
  localparam logic [7:0] REG_CNT      = 8'h01;
  localparam logic [7:0] REG_STAT     = 8'h02;
  localparam logic [7:0] REG_ID       = 8'h03;
  localparam logic [7:0] REG_UNMAPPED = 8'hFF;

  localparam logic [6:0] DEFAULT_ADDR = 7'h0A;

  function automatic logic [7:0] reg_read(
    input logic [7:0] ptr,
    input logic [7:0] hr,
    input logic [7:0] cnt,
    input logic       new_flag,
    input logic [6:0] addr
  );
    case (ptr)
      REG_HR:   reg_read = hr;
      REG_CNT:  reg_read = cnt;
      REG_STAT: reg_read = {7'd0, new_flag};
      REG_ID:   reg_read = {1'b0, addr};
      default:  reg_read = REG_UNMAPPED;
    endcase
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes the asynchronous SCL/SDA pins and derives SCL edges and
// START/STOP bus conditions from the last synchronizer stage.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;
  logic                   scl_s;

  // Edges are combinational against the previous sample so the FSM reacts on
  // the very next clk edge, giving SYNC_STAGES+1 cycles pin-to-output.
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    scl_s      = scl_sync_q[SYNC_STAGES-1];
    sda_s      = sda_sync_q[SYNC_STAGES-1];
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
    scl_rise   = scl_s & ~scl_prev_q;
    scl_fall   = ~scl_s & scl_prev_q;
    start_det  = scl_s & sda_prev_q & ~sda_s;
    stop_det   = scl_s & ~sda_prev_q & sda_s;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

endmodule

// File: rtl/i2c_target_hr.sv
// I2C target serving heart-rate registers (pointer write, then repeated-START read).
// Optional stalled-bus abort is enabled by defining I2C_TIMEOUT_EN.
module i2c_target_hr
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR        = DEFAULT_ADDR,
  parameter int         SYNC_STAGES = 2
`ifdef I2C_TIMEOUT_EN
  ,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] batimento,
  input  logic       batimento_valid,
  output logic       busy,
  output logic [7:0] reg_ptr
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bus_sync (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det),
    .sda_s    (sda_s)
  );

  i2c_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] reg_ptr_q, reg_ptr_d;
  logic [7:0] hr_q, hr_d;
  logic [7:0] cnt_q, cnt_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       new_flag_q, new_flag_d;
  logic       ptr_written_q, ptr_written_d;
  logic       load_en, load_fire, timeout;
  logic [7:0] rd_data;

`ifdef I2C_TIMEOUT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + 16'd1;
    if (state_q == ST_IDLE || scl_rise || scl_fall) stall_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign timeout = (stall_cnt_q == TIMEOUT_CYCLES);
`else
  assign timeout = 1'b0;
`endif

  assign rd_data   = reg_read(reg_ptr_q, hr_q, cnt_q, new_flag_q, ADDR);
  assign load_fire = load_en & ~start_det & ~stop_det & ~timeout;

  // Bus FSM: SDA sampled on SCL rise, sda_oe only ever moves on SCL fall.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    reg_ptr_d     = reg_ptr_q;
    sda_oe_d      = sda_oe_q;
    busy_d        = busy_q;
    ptr_written_d = ptr_written_q;
    load_en       = 1'b0;

    case (state_q)
      ST_IDLE: begin
      end
      ST_ADDR: begin
        if (scl_rise) begin
          shift_d   = {shift_q[6:0], sda_s};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (scl_fall && bit_cnt_q == 4'd8) begin
          bit_cnt_d = '0;
          if (shift_q[7:1] == ADDR) begin
            busy_d   = 1'b1;
            sda_oe_d = 1'b1;
            state_d  = ST_ACK_ADDR;
          end else begin
            state_d  = ST_IGNORE;
          end
        end
      end
      ST_ACK_ADDR: begin
        if (scl_fall) begin
          if (shift_q[0]) begin
            load_en = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = ST_RX_REG;
          end
        end
      end
      ST_RX_REG: begin
        if (scl_rise) begin
          shift_d   = {shift_q[6:0], sda_s};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (scl_fall && bit_cnt_q == 4'd8) begin
          bit_cnt_d = '0;
          state_d   = ST_ACK_REG;
          if (!ptr_written_q) begin
            reg_ptr_d     = shift_q;
            ptr_written_d = 1'b1;
            sda_oe_d      = 1'b1;
          end
        end
      end
      // sda_oe_q doubles as the "this byte was ACKed" flag.
      ST_ACK_REG: begin
        if (scl_fall) begin
          sda_oe_d = 1'b0;
          state_d  = sda_oe_q ? ST_RX_REG : ST_IGNORE;
        end
      end
      ST_TX: begin
        if (scl_fall) begin
          if (bit_cnt_q == 4'd8) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = ST_ACK_CHK;
          end else if (bit_cnt_q == 4'd0) begin
            load_en = 1'b1;
          end else begin
            sda_oe_d  = ~shift_q[7];
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_ACK_CHK: begin
        if (scl_rise) begin
          if (!sda_s) begin
            reg_ptr_d = reg_ptr_q + 8'd1;
            bit_cnt_d = '0;
            state_d   = ST_TX;
          end else begin
            state_d   = ST_IGNORE;
          end
        end
      end
      ST_IGNORE: begin
        sda_oe_d = 1'b0;
      end
      default: begin
        state_d  = ST_IDLE;
        sda_oe_d = 1'b0;
      end
    endcase

    // A load puts the first (MSB) bit on the bus in the same falling edge.
    if (load_en) begin
      shift_d   = {rd_data[6:0], 1'b0};
      sda_oe_d  = ~rd_data[7];
      bit_cnt_d = 4'd1;
      state_d   = ST_TX;
    end

    if (timeout) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end

    if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d       = ST_ADDR;
      bit_cnt_d     = '0;
      sda_oe_d      = 1'b0;
      busy_d        = 1'b0;
      ptr_written_d = 1'b0;
    end
  end

  // A strobe wins over the clear so a same-cycle sample is not lost.
  always_comb begin
    hr_d       = hr_q;
    cnt_d      = cnt_q;
    new_flag_d = new_flag_q;
    if (load_fire && reg_ptr_q == REG_HR) new_flag_d = 1'b0;
    if (batimento_valid) begin
      hr_d       = batimento;
      cnt_d      = cnt_q + 8'd1;
      new_flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      reg_ptr_q     <= '0;
      hr_q          <= '0;
      cnt_q         <= '0;
      sda_oe_q      <= 1'b0;
      busy_q        <= 1'b0;
      new_flag_q    <= 1'b0;
      ptr_written_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      reg_ptr_q     <= reg_ptr_d;
      hr_q          <= hr_d;
      cnt_q         <= cnt_d;
      sda_oe_q      <= sda_oe_d;
      busy_q        <= busy_d;
      new_flag_q    <= new_flag_d;
      ptr_written_q <= ptr_written_d;
    end
  end

  assign sda_oe  = sda_oe_q;
  assign busy    = busy_q;
  assign reg_ptr = reg_ptr_q;

endmodule

// File: tb/tb_i2c_target_hr.sv
// Directed bench for i2c_target_hr: a bit-banged I2C master on a wired-AND
// SDA line, with hand-computed expected register contents.
module tb_i2c_target_hr;

  localparam int QTR = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_in;
  logic       m_sda;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] batimento;
  logic       batimento_valid;
  logic       busy;
  logic [7:0] reg_ptr;

  int checks   = 0;
  int failures = 0;

  assign sda_in = m_sda & ~sda_oe;

  always #5 clk = ~clk;

`ifdef I2C_TIMEOUT_EN
  i2c_target_hr #(.TIMEOUT_CYCLES(16'd100)) dut (
    .clk(clk), .reset(reset), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
    .batimento(batimento), .batimento_valid(batimento_valid), .busy(busy), .reg_ptr(reg_ptr)
  );
`else
  i2c_target_hr dut (
    .clk(clk), .reset(reset), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
    .batimento(batimento), .batimento_valid(batimento_valid), .busy(busy), .reg_ptr(reg_ptr)
  );
`endif

  function automatic logic [7:0] b8(input logic b);
    return {7'd0, b};
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic busStart();
    m_sda = 1'b1; scl_in = 1'b1; waitClk(QTR);
    m_sda = 1'b0; waitClk(QTR);
    scl_in = 1'b0; waitClk(QTR);
  endtask

  task automatic busRestart();
    m_sda = 1'b1; waitClk(QTR);
    scl_in = 1'b1; waitClk(QTR);
    m_sda = 1'b0; waitClk(QTR);
    scl_in = 1'b0; waitClk(QTR);
  endtask

  task automatic busStop();
    m_sda = 1'b0; waitClk(QTR);
    scl_in = 1'b1; waitClk(QTR);
    m_sda = 1'b1; waitClk(QTR);
  endtask

  // One SCL period; bus level and target drive are sampled mid-high.
  task automatic clockBit(input logic b, output logic bus_val, output logic oe_val);
    m_sda = b; waitClk(QTR);
    scl_in = 1'b1; waitClk(QTR);
    bus_val = sda_in;
    oe_val  = sda_oe;
    waitClk(QTR);
    scl_in = 1'b0; waitClk(QTR);
  endtask

  // Master writes a byte; reports any target drive during data bits and the ACK bit.
  task automatic applyStimulus(input logic [7:0] data, output logic data_oe, output logic ack_oe);
    logic bv, ov;
    data_oe = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      clockBit(data[i], bv, ov);
      data_oe = data_oe | ov;
    end
    clockBit(1'b1, bv, ov);
    ack_oe = ov;
  endtask

  task automatic readByte(input logic master_nack, output logic [7:0] data, output logic ack_oe);
    logic bv, ov;
    for (int i = 7; i >= 0; i--) begin
      clockBit(1'b1, bv, ov);
      data[i] = bv;
    end
    clockBit(master_nack, bv, ov);
    ack_oe = ov;
  endtask

  task automatic strobe(input logic [7:0] v);
    waitClk(1);
    batimento = v; batimento_valid = 1'b1;
    waitClk(1);
    batimento_valid = 1'b0;
    waitClk(2);
  endtask

  task automatic writePtr(input string tag, input logic [7:0] ptr);
    logic d_oe, a_oe;
    busStart();
    applyStimulus(8'h14, d_oe, a_oe);
    checkOutput({tag, "_addr_ack"}, b8(a_oe), 8'h01);
    applyStimulus(ptr, d_oe, a_oe);
    checkOutput({tag, "_ptr_ack"}, b8(a_oe), 8'h01);
  endtask

  task automatic readStart(input string tag);
    logic d_oe, a_oe;
    busRestart();
    applyStimulus(8'h15, d_oe, a_oe);
    checkOutput({tag, "_raddr_ack"}, b8(a_oe), 8'h01);
  endtask

  initial begin
    logic       d_oe, a_oe, bv, ov;
    logic [7:0] rd;

    reset = 1'b0; scl_in = 1'b1; m_sda = 1'b1;
    batimento = 8'd0; batimento_valid = 1'b0;
    waitClk(5);
    checkOutput("rst_sda_oe", b8(sda_oe), 8'h00);
    checkOutput("rst_busy", b8(busy), 8'h00);
    checkOutput("rst_reg_ptr", reg_ptr, 8'h00);
    reset = 1'b1;
    waitClk(5);

    // Pointer write then repeated-START read of the heart-rate byte.
    strobe(8'd72);
    busStart();
    applyStimulus(8'h14, d_oe, a_oe);
    checkOutput("t1_addr_data_oe", b8(d_oe), 8'h00);
    checkOutput("t1_addr_ack", b8(a_oe), 8'h01);
    checkOutput("t1_busy", b8(busy), 8'h01);
    applyStimulus(8'h00, d_oe, a_oe);
    checkOutput("t1_ptr_data_oe", b8(d_oe), 8'h00);
    checkOutput("t1_ptr_ack", b8(a_oe), 8'h01);
    readStart("t1");
    readByte(1'b1, rd, a_oe);
    checkOutput("t1_read_hr", rd, 8'h48);
    checkOutput("t1_master_ack_oe", b8(a_oe), 8'h00);
    busStop();
    checkOutput("t1_busy_after_stop", b8(busy), 8'h00);
    checkOutput("t1_oe_after_stop", b8(sda_oe), 8'h00);

    // Wrong address, then a matching byte that must still be ignored.
    busStart();
    applyStimulus(8'h16, d_oe, a_oe);
    checkOutput("t2_data_oe", b8(d_oe), 8'h00);
    checkOutput("t2_no_ack", b8(a_oe), 8'h00);
    checkOutput("t2_busy", b8(busy), 8'h00);
    applyStimulus(8'h14, d_oe, a_oe);
    checkOutput("t2_ignore_ack", b8(a_oe), 8'h00);
    busStop();

    // Reset while the target drives a 0 bit (MSB of ID register 0x0A).
    writePtr("t5", 8'h03);
    readStart("t5");
    checkOutput("t5_tx_drive", b8(sda_oe), 8'h01);
    checkOutput("t5_busy", b8(busy), 8'h01);
    checkOutput("t5_ptr", reg_ptr, 8'h03);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("t5_rst_oe", b8(sda_oe), 8'h00);
    checkOutput("t5_rst_busy", b8(busy), 8'h00);
    checkOutput("t5_rst_ptr", reg_ptr, 8'h00);
    waitClk(2);
    reset = 1'b1;
    m_sda = 1'b1;
    waitClk(4);
    busStop();

    // Sample counter, new flag and ID with auto-increment.
    strobe(8'h10);
    strobe(8'h20);
    strobe(8'h30);
    writePtr("t3", 8'h01);
    readStart("t3");
    readByte(1'b0, rd, a_oe);
    checkOutput("t3_cnt", rd, 8'h03);
    readByte(1'b0, rd, a_oe);
    checkOutput("t3_stat", rd, 8'h01);
    readByte(1'b1, rd, a_oe);
    checkOutput("t3_id", rd, 8'h0A);
    busStop();
    checkOutput("t3_ptr_end", reg_ptr, 8'h03);

    // Second write byte is NACKed; pointer wraps 0xFF -> 0x00 on read.
    busStart();
    applyStimulus(8'h14, d_oe, a_oe);
    checkOutput("t4_addr_ack", b8(a_oe), 8'h01);
    applyStimulus(8'hFF, d_oe, a_oe);
    checkOutput("t4_ptr_ack", b8(a_oe), 8'h01);
    applyStimulus(8'h55, d_oe, a_oe);
    checkOutput("t4_extra_nack", b8(a_oe), 8'h00);
    checkOutput("t4_ptr_kept", reg_ptr, 8'hFF);
    readStart("t4");
    readByte(1'b0, rd, a_oe);
    checkOutput("t4_unmapped", rd, 8'hFF);
    readByte(1'b1, rd, a_oe);
    checkOutput("t4_wrap_hr", rd, 8'h30);
    busStop();
    checkOutput("t4_ptr_wrap", reg_ptr, 8'h00);

    // Strobe landing on the same clk as the reg 0x00 load.
    writePtr("t6", 8'h00);
    busRestart();
    for (int i = 7; i >= 0; i--) begin
      rd = 8'h15;
      clockBit(rd[i], bv, ov);
    end
    m_sda = 1'b1; waitClk(QTR);
    scl_in = 1'b1; waitClk(QTR);
    a_oe = sda_oe;
    waitClk(QTR);
    scl_in = 1'b0;
    waitClk(2);
    batimento = 8'd90; batimento_valid = 1'b1;
    waitClk(1);
    batimento_valid = 1'b0;
    waitClk(QTR - 3);
    checkOutput("t6_raddr_ack", b8(a_oe), 8'h01);
    readByte(1'b1, rd, a_oe);
    checkOutput("t6_old_hr", rd, 8'h30);
    busStop();
    writePtr("t6b", 8'h02);
    readStart("t6b");
    readByte(1'b1, rd, a_oe);
    checkOutput("t6_flag_kept", rd, 8'h01);
    busStop();
    writePtr("t6c", 8'h00);
    readStart("t6c");
    readByte(1'b1, rd, a_oe);
    checkOutput("t6_new_hr", rd, 8'h5A);
    busStop();

`ifdef I2C_TIMEOUT_EN
    // SCL parked low mid-byte must abort the transfer.
    busStart();
    applyStimulus(8'h14, d_oe, a_oe);
    checkOutput("to_addr_ack", b8(a_oe), 8'h01);
    checkOutput("to_busy_before", b8(busy), 8'h01);
    for (int i = 0; i < 3; i++) clockBit(1'b1, bv, ov);
    waitClk(130);
    checkOutput("to_busy_after", b8(busy), 8'h00);
    checkOutput("to_oe_after", b8(sda_oe), 8'h00);
    busStop();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_target_hr.md
Name: i2c_target_hr

Overview:
- Synthesizable I2C target (responder) that serves heart-rate data to the I2C master controller on the same bus.
- Oversamples SCL/SDA with the system clock and drives SDA open-drain via an output-enable.
- Exposes a small register map: heart-rate byte, sample counter, status. The master first writes a register pointer, then reads with a repeated START.

Parameters:
- ADDR, 7'h0A, 7-bit target address matched in the address byte.
- SYNC_STAGES, 2, flip-flop synchronizer depth on scl_in and sda_in (minimum 2).
- TIMEOUT_CYCLES, 16'd50000, clk cycles of static SCL before abort (used only with I2C_TIMEOUT_EN).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-low reset.
- scl_in  input  1  bus SCL level, asynchronous.
- sda_in  input  1  bus SDA level, asynchronous.
- sda_oe  output  1  1 = pull SDA low; 0 = release.
- batimento  input  8  latest heart-rate value, bpm.
- batimento_valid  input  1  one-cycle strobe: batimento is new.
- busy  output  1  high from a matched address until STOP, START or abort.
- reg_ptr  output  8  current register pointer, for debug and the bench.

Behaviour:
- Reset (reset=0 at a clk edge):
  - sda_oe=0, busy=0, reg_ptr=0, hr_reg=0, cnt_reg=0.
  - State IDLE; synchronizers set to 1.
  - Reset mid-transfer releases SDA on the next clk edge.
- Synchronized signals scl_s and sda_s come from the last synchronizer stage; edges are detected against the previous sample.
- Bus conditions:
  - START: sda_s falls while scl_s=1.
  - STOP: sda_s rises while scl_s=1.
  - START from any state (repeated START included): bit_cnt=0, go to ADDR, sda_oe=0.
  - STOP from any state: go to IDLE, sda_oe=0, busy=0.
  - START and STOP take priority over SCL edges detected in the same cycle.
- Bit timing:
  - SDA is sampled on the scl_s rising edge.
  - sda_oe changes only on the scl_s falling edge, so it never changes while SCL is high.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits, MSB first.
    - Bits [7:1]==ADDR: assert busy, go to ACK_ADDR.
    - Mismatch: go to IGNORE.
  - ACK_ADDR: drive sda_oe=1 for the 9th bit.
    - At the falling edge ending it, bit 0=0 (write) → RX_REG, sda_oe=0.
    - Bit 0=1 (read) → load shift register from register map at reg_ptr, go to TX, and drive its MSB.
  - RX_REG: shift 8 bits, then ACK_REG.
    - First data byte after the address: reg_ptr := byte, sent with ACK.
    - Further bytes in the same write: NACK (sda_oe=0 during the 9th bit), then IGNORE.
  - TX: on each falling edge, sda_oe = ~shift[7] (drive low for a 0 bit), then shift left. After the 8th bit, release SDA and go to ACK_CHK.
  - ACK_CHK: sample SDA on the 9th rising edge.
    - 0 (master ACK): reg_ptr+1 (wrap 0xFF→0x00), reload, return to TX.
    - 1 (NACK): go to IGNORE.
  - IGNORE: sda_oe=0; wait for START or STOP.
- Register map (read), all other pointers read 8'hFF:
  - 0x00 = hr_reg.
  - 0x01 = cnt_reg (count of batimento_valid strobes, wraps at 255).
  - 0x02 = {7'b0, new_flag}; new_flag is set by a strobe and cleared when reg 0x00 is loaded into the shift register.
  - 0x03 = ADDR padded to {1'b0, ADDR}.
- Snapshot:
  - hr_reg <= batimento on batimento_valid, independent of bus state.
  - A byte already in the shift register is never modified mid-byte.
  - Strobe in the same cycle as a reg 0x00 load: the load gets the old value, new_flag stays set.
- Latency: from an SCL falling edge at the pin to the sda_oe update is SYNC_STAGES+1 clk cycles; clk must be ≥ 8× SCL frequency.

Optional Feature:
- Macro I2C_TIMEOUT_EN.
- Defined: a 16-bit counter clears on any scl_s edge and increments while state≠IDLE. When it reaches TIMEOUT_CYCLES: go to IDLE, sda_oe=0, busy=0.
- Undefined: no counter; a stalled bus holds state indefinitely.

Decomposition:
- Shared package/header i2c_pkg: state encodings, register indices (REG_HR=0, REG_CNT=1, REG_STAT=2, REG_ID=3), default ADDR 7'h0A.
- Sub-module i2c_bus_sync: synchronizers plus edge/START/STOP detection. Outputs scl_rise, scl_fall, start_det, stop_det, sda_s.

Test Plan:
- Write 0x14 (addr 0x0A, W), data 0x00; repeated START; 0x15 (R), master NACK, with batimento=72 strobed beforehand → read byte 0x48; sda_oe=1 exactly during both ACK bits; busy low after STOP.
- Address 0x0B W → no ACK (sda_oe stays 0 for all 9 bits); state IGNORE until STOP.
- Pointer 0x01, 3 strobes, read 3 bytes with ACK, ACK, NACK → 0x03, new_flag 0x01, 0x0A; reg_ptr=0x03 at the end.
- Pointer 0xFF, read 2 bytes with ACK → 0xFF then 0x00 contents (wrap); second write data byte 0x55 → NACK.
- reset=0 while in TX driving a 0 bit → sda_oe=0 next clk, busy=0, reg_ptr=0. With I2C_TIMEOUT_EN and TIMEOUT_CYCLES=100: SCL held low mid-byte → IDLE after 100 cycles.
- Strobe batimento=90 on the same clk as the reg 0x00 load → returned byte is the old value; a subsequent read of 0x02 returns 0x01.
